mining_dispatcher: RTL and testbench

Parametrised mining controller that sits between the UART byte links and a bank of `NUM_CORES` SHA-256 hash cores. It takes framed commands from the host: load a 76-byte header base, load a 256-bit target, start, abort. It deals a strided nonce range across the cores, compares every returned hash against the target and reports the winning nonce, exhaustion or abort back over UART. It replaces the single-core, fixed-header mining loop in the top-level miner.

---
 rtl/mining_dispatcher.sv | 258 +++++++++++++++++++++++++
 tb/tb_mining_dispatcher.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mining_dispatcher.sv
// Multi-core mining controller: takes framed UART commands, deals a strided nonce range across
// NUM_CORES hash cores, compares results against the target and reports hit/exhaustion/abort.
module mining_dispatcher #(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned NONCE_W   = 32,
    parameter int unsigned HDR_BYTES = 76
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [7:0]                     rx_data,
    input  logic                           rx_ready,
    output logic [7:0]                     tx_data,
    output logic                           tx_start,
    input  logic                           tx_busy,
    output logic [8*HDR_BYTES-1:0]         core_header,
    output logic [NUM_CORES*NONCE_W-1:0]   core_nonce,
    output logic [NUM_CORES-1:0]           core_start,
    input  logic [NUM_CORES-1:0]           core_ready,
    input  logic [NUM_CORES*256-1:0]       core_hash,
    output logic                           mining,
    output logic                           found
);

    localparam int unsigned NonceBytes = (NONCE_W + 7) / 8;
    localparam int unsigned HdrW       = 8 * HDR_BYTES;
    localparam int unsigned IdxW       = $clog2(NonceBytes + 1);

    typedef enum logic [2:0] {StIdle, StRxHdr, StRxTgt, StMine, StDrain, StTx} state_e;

    state_e                         state_q, state_d;
    logic [7:0]                     cnt_q, cnt_d;
    logic [HdrW-1:0]                header_q, header_d;
    logic [255:0]                   target_q, target_d;
    logic [NUM_CORES*NONCE_W-1:0]   nonce_q, nonce_d;
    logic [NUM_CORES-1:0]           start_q, start_d;
    logic [NUM_CORES-1:0]           busy_q, busy_d;
    logic [NUM_CORES-1:0]           retired_q, retired_d;
    logic                           found_q, found_d;
    logic                           abort_q, abort_d;
    logic [NonceBytes*8-1:0]        win_q, win_d;
    logic [IdxW-1:0]                tx_idx_q, tx_idx_d;
    logic [1:0]                     tx_ph_q, tx_ph_d;
    logic                           tx_start_q, tx_start_d;
    logic [7:0]                     tx_data_q, tx_data_d;

    logic [NUM_CORES-1:0]           valid_v, hit_v, ovf_v;
    logic [NUM_CORES*NONCE_W-1:0]   next_nonce;
    logic [NONCE_W-1:0]             win_nonce;
    logic [NonceBytes*8-1:0]        win_shift;
    logic [7:0]                     tx_byte;
    logic [IdxW-1:0]                msg_last;
    logic                           cmd_abort;

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
        logic [NONCE_W:0] sum;
        // One extra bit so stepping past the top of the nonce space is visible.
        assign sum = {1'b0, nonce_q[g*NONCE_W +: NONCE_W]} + (NONCE_W+1)'(NUM_CORES);
        assign valid_v[g] = core_ready[g] & busy_q[g];
        assign hit_v[g]   = valid_v[g] & (core_hash[g*256 +: 256] < target_q);
        assign ovf_v[g]   = sum[NONCE_W];
        assign next_nonce[g*NONCE_W +: NONCE_W] = sum[NONCE_W-1:0];
    end

    // Descending scan so the lowest-index hitting core wins.
    always_comb begin
        win_nonce = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            if (hit_v[k]) begin
                win_nonce = nonce_q[k*NONCE_W +: NONCE_W];
            end
        end
    end

    assign cmd_abort = rx_ready && (rx_data == 8'h04);
    assign win_shift = win_q >> {tx_idx_q - IdxW'(1), 3'b000};
    assign msg_last  = (found_q && !abort_q) ? IdxW'(NonceBytes) : '0;

    always_comb begin
        tx_byte = win_shift[7:0];
        if (tx_idx_q == '0) begin
            tx_byte = abort_q ? 8'hAB : (found_q ? 8'hA5 : 8'h5A);
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        header_d   = header_q;
        target_d   = target_q;
        nonce_d    = nonce_q;
        start_d    = '0;
        retired_d  = retired_q;
        found_d    = found_q;
        abort_d    = abort_q;
        win_d      = win_q;
        tx_idx_d   = tx_idx_q;
        tx_ph_d    = tx_ph_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;

        case (state_q)
            StIdle: begin
                if (rx_ready) begin
                    case (rx_data)
                        8'h01: begin
                            state_d = StRxHdr;
                            cnt_d   = '0;
                        end
                        8'h02: begin
                            state_d = StRxTgt;
                            cnt_d   = '0;
                        end
                        8'h03: begin
                            found_d   = 1'b0;
                            abort_d   = 1'b0;
                            retired_d = '0;
                            start_d   = '1;
                            for (int k = 0; k < NUM_CORES; k++) begin
                                nonce_d[k*NONCE_W +: NONCE_W] = NONCE_W'(k);
                            end
                            state_d = StMine;
                        end
                        default: ;
                    endcase
                end
            end
            StRxHdr: begin
                if (rx_ready) begin
                    header_d = (header_q << 8) | HdrW'(rx_data);
                    cnt_d    = cnt_q + 8'd1;
                    if (cnt_q == 8'(HDR_BYTES - 1)) begin
                        state_d = StIdle;
                    end
                end
            end
            StRxTgt: begin
                if (rx_ready) begin
                    target_d = (target_q << 8) | 256'(rx_data);
                    cnt_d    = cnt_q + 8'd1;
                    if (cnt_q == 8'd31) begin
                        state_d = StIdle;
                    end
                end
            end
            StMine: begin
                if (cmd_abort) begin
                    abort_d = 1'b1;
                    state_d = StDrain;
                end else if (|hit_v) begin
                    found_d = 1'b1;
                    win_d   = '0;
                    win_d[NONCE_W-1:0] = win_nonce;
                    state_d = StDrain;
                end else begin
                    for (int k = 0; k < NUM_CORES; k++) begin
                        if (valid_v[k]) begin
                            if (ovf_v[k]) begin
                                retired_d[k] = 1'b1;
                            end else begin
                                nonce_d[k*NONCE_W +: NONCE_W] = next_nonce[k*NONCE_W +: NONCE_W];
                                start_d[k] = 1'b1;
                            end
                        end
                    end
                    if ((&retired_q) && (busy_q == '0)) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (cmd_abort) begin
                    abort_d = 1'b1;
                end
                if (busy_q == '0) begin
                    state_d  = StTx;
                    tx_idx_d = '0;
                    tx_ph_d  = 2'd0;
                end
            end
            StTx: begin
                // Phases: 0 issue byte, 1 wait for busy to rise, 2 wait for busy to fall.
                case (tx_ph_q)
                    2'd0: begin
                        if (!tx_busy) begin
                            tx_start_d = 1'b1;
                            tx_data_d  = tx_byte;
                            tx_ph_d    = 2'd1;
                        end
                    end
                    2'd1: begin
                        if (tx_busy) begin
                            tx_ph_d = 2'd2;
                        end
                    end
                    2'd2: begin
                        if (!tx_busy) begin
                            tx_ph_d = 2'd0;
                            if (tx_idx_q == msg_last) begin
                                state_d = StIdle;
                            end else begin
                                tx_idx_d = tx_idx_q + IdxW'(1);
                            end
                        end
                    end
                    default: tx_ph_d = 2'd0;
                endcase
            end
            default: state_d = StIdle;
        endcase

        busy_d = (busy_q & ~core_ready) | start_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            header_q   <= '0;
            target_q   <= '0;
            nonce_q    <= '0;
            start_q    <= '0;
            busy_q     <= '0;
            retired_q  <= '0;
            found_q    <= 1'b0;
            abort_q    <= 1'b0;
            win_q      <= '0;
            tx_idx_q   <= '0;
            tx_ph_q    <= 2'd0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            header_q   <= header_d;
            target_q   <= target_d;
            nonce_q    <= nonce_d;
            start_q    <= start_d;
            busy_q     <= busy_d;
            retired_q  <= retired_d;
            found_q    <= found_d;
            abort_q    <= abort_d;
            win_q      <= win_d;
            tx_idx_q   <= tx_idx_d;
            tx_ph_q    <= tx_ph_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_start    = tx_start_q;
    assign core_header = header_q;
    assign core_nonce  = nonce_q;
    assign core_start  = start_q;
    assign found       = found_q;
    assign mining      = (state_q == StMine) || (state_q == StDrain);

endmodule

// File: tb/tb_mining_dispatcher.sv
// Bench for mining_dispatcher: behavioural hash cores and UART transmitter, with a byte
// scoreboard filled when a run is started and drained as the DUT transmits.
module tb_mining_dispatcher;

    localparam int NC = 4;
    localparam int NW = 12;
    localparam int HB = 76;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [7:0]           rx_data;
    logic                 rx_ready;
    logic [7:0]           tx_data;
    logic                 tx_start;
    logic                 tx_busy;
    logic [8*HB-1:0]      core_header;
    logic [NC*NW-1:0]     core_nonce;
    logic [NC-1:0]        core_start;
    logic [NC-1:0]        core_ready;
    logic [NC*256-1:0]    core_hash;
    logic                 mining;
    logic                 found;

    mining_dispatcher #(.NUM_CORES(NC), .NONCE_W(NW), .HDR_BYTES(HB)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .core_header(core_header), .core_nonce(core_nonce), .core_start(core_start),
        .core_ready(core_ready), .core_hash(core_hash), .mining(mining), .found(found)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    int lat [NC];
    int cnt [NC];
    logic [NW-1:0] nonce_m [NC];
    int hit_nonce;
    int blen;
    int bcnt;
    logic [7:0] exp_q [$];
    logic [NW-1:0] core1_log [$];
    int n_starts, starts_after_found, starts_after_abort, tx_while_busy;
    bit abort_sent;
    logic [8*HB-1:0] hdr_exp;
    logic [NC*NW-1:0] nonce_exp;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] hashf(input logic [NW-1:0] n);
        if (int'(n) == hit_nonce) return '0;
        return {{255{1'b1}}, 1'b0};
    endfunction

    // Behavioural UART transmitter and hash cores, all acting on the falling edge.
    always @(negedge clk) begin
        if (tx_start) begin
            if (exp_q.size() == 0) check_eq("tx_queue_occupancy", 256'(exp_q.size()), 256'd1);
            else check_eq("tx_byte", 256'(tx_data), 256'(exp_q.pop_front()));
            for (int k = 0; k < NC; k++) if (cnt[k] != 0) tx_while_busy++;
            tx_busy = 1'b1;
            bcnt = blen;
        end else if (bcnt > 0) begin
            bcnt--;
            if (bcnt == 0) tx_busy = 1'b0;
        end
        if (!reset) begin
            tx_busy = 1'b0;
            bcnt = 0;
        end
        core_ready = '0;
        for (int k = 0; k < NC; k++) begin
            if (!reset) begin
                cnt[k] = 0;
            end else if (core_start[k]) begin
                if (found) starts_after_found++;
                if (abort_sent) starts_after_abort++;
                n_starts++;
                cnt[k] = lat[k];
                nonce_m[k] = core_nonce[k*NW +: NW];
                if (k == 1) core1_log.push_back(nonce_m[k]);
            end else if (cnt[k] != 0) begin
                cnt[k]--;
                if (cnt[k] == 0) begin
                    core_ready[k] = 1'b1;
                    core_hash[k*256 +: 256] = hashf(nonce_m[k]);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic load_hdr();
        send_byte(8'h01);
        for (int i = 0; i < HB; i++) send_byte(8'(i));
    endtask

    task automatic load_tgt(input logic [255:0] t);
        send_byte(8'h02);
        for (int i = 0; i < 32; i++) send_byte(t[255 - 8*i -: 8]);
    endtask

    task automatic set_lat(input int base, input int step);
        for (int k = 0; k < NC; k++) lat[k] = base + step * k;
    endtask

    task automatic clear_stats();
        n_starts = 0;
        starts_after_found = 0;
        starts_after_abort = 0;
        tx_while_busy = 0;
        abort_sent = 1'b0;
        core1_log.delete();
    endtask

    task automatic wait_msg(input int budget);
        for (int i = 0; i < budget && (exp_q.size() != 0 || tx_busy || mining); i++)
            @(negedge clk);
        repeat (3) @(negedge clk);
        check_eq("msg_complete", 256'(exp_q.size()), 256'd0);
        check_eq("idle_after_msg", 256'(mining), 256'd0);
    endtask

    task automatic start_and_check(input string tag);
        send_byte(8'h03);
        check_eq({tag, "_core_start"}, 256'(core_start), 256'hF);
        check_eq({tag, "_core_nonce"}, 256'(core_nonce), 256'(nonce_exp));
        check_eq({tag, "_mining"}, 256'(mining), 256'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        rx_data = '0;
        rx_ready = 1'b0;
        tx_busy = 1'b0;
        core_ready = '0;
        core_hash = '0;
        hit_nonce = -1;
        blen = 4;
        bcnt = 0;
        set_lat(10, 0);
        for (int k = 0; k < NC; k++) cnt[k] = 0;
        clear_stats();
        for (int i = 0; i < HB; i++) hdr_exp[(HB-1-i)*8 +: 8] = 8'(i);
        for (int k = 0; k < NC; k++) nonce_exp[k*NW +: NW] = NW'(k);

        repeat (3) @(negedge clk);
        check_eq("rst_tx_start", 256'(tx_start), 256'd0);
        check_eq("rst_tx_data", 256'(tx_data), 256'd0);
        check_eq("rst_core_start", 256'(core_start), 256'd0);
        check_eq("rst_core_nonce", 256'(core_nonce), 256'd0);
        check_eq("rst_core_header", 256'(core_header != '0), 256'd0);
        check_eq("rst_mining", 256'(mining), 256'd0);
        check_eq("rst_found", 256'(found), 256'd0);
        reset = 1'b1;

        // All cores finish together and all hit: core 0 (nonce 0) wins; stray byte ignored.
        load_hdr();
        load_tgt('1);
        send_byte(8'h77);
        check_eq("header_loaded", 256'(core_header == hdr_exp), 256'd1);
        exp_q.push_back(8'hA5); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        start_and_check("t1");
        wait_msg(2000);
        check_eq("t1_found", 256'(found), 256'd1);
        check_eq("t1_header_kept", 256'(core_header == hdr_exp), 256'd1);

        // Nothing beats a zero target: every core walks its stride to the top and retires.
        set_lat(2, 0);
        load_tgt('0);
        clear_stats();
        exp_q.push_back(8'h5A);
        start_and_check("t2");
        wait_msg(30000);
        check_eq("t2_found", 256'(found), 256'd0);
        check_eq("t2_total_jobs", 256'(n_starts), 256'd4096);
        check_eq("t2_core1_jobs", 256'(core1_log.size()), 256'd1024);
        if (core1_log.size() >= 4) begin
            check_eq("t2_core1_n0", 256'(core1_log[0]), 256'd1);
            check_eq("t2_core1_n1", 256'(core1_log[1]), 256'd5);
            check_eq("t2_core1_n2", 256'(core1_log[2]), 256'd9);
            check_eq("t2_core1_n3", 256'(core1_log[3]), 256'd13);
            check_eq("t2_core1_last", 256'(core1_log[core1_log.size()-1]), 256'd4093);
        end

        // Single hitting nonce 0x106 with staggered latencies; reported LSB first.
        set_lat(5, 1);
        load_tgt(256'h1);
        hit_nonce = 'h106;
        clear_stats();
        exp_q.push_back(8'hA5); exp_q.push_back(8'h06); exp_q.push_back(8'h01);
        start_and_check("t3");
        wait_msg(5000);
        check_eq("t3_found", 256'(found), 256'd1);
        check_eq("t3_starts_after_hit", 256'(starts_after_found), 256'd0);
        check_eq("t3_tx_while_core_busy", 256'(tx_while_busy), 256'd0);

        // Abort mid-run.
        hit_nonce = -1;
        set_lat(10, 0);
        clear_stats();
        exp_q.push_back(8'hAB);
        start_and_check("t4");
        repeat (50) @(negedge clk);
        send_byte(8'h04);
        @(negedge clk);
        abort_sent = 1'b1;
        wait_msg(2000);
        check_eq("t4_found", 256'(found), 256'd0);
        check_eq("t4_starts_after_abort", 256'(starts_after_abort), 256'd0);
        check_eq("t4_tx_while_core_busy", 256'(tx_while_busy), 256'd0);

        // Reset in the middle of a transmission, then a clean run from nonce k.
        set_lat(3, 0);
        load_tgt('1);
        blen = 40;
        clear_stats();
        exp_q.push_back(8'hA5); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        start_and_check("t5");
        for (int i = 0; i < 500 && !tx_busy; i++) @(negedge clk);
        check_eq("t5_tx_in_progress", 256'(tx_busy), 256'd1);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("t5_rst_tx_start", 256'(tx_start), 256'd0);
        check_eq("t5_rst_mining", 256'(mining), 256'd0);
        check_eq("t5_rst_found", 256'(found), 256'd0);
        check_eq("t5_rst_core_nonce", 256'(core_nonce), 256'd0);
        check_eq("t5_rst_header", 256'(core_header != '0), 256'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        blen = 4;
        load_tgt('1);
        clear_stats();
        exp_q.push_back(8'hA5); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        start_and_check("t6");
        wait_msg(2000);
        check_eq("t6_found", 256'(found), 256'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
